// File: rtl/ex_muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply and restoring divide,
// one bit per cycle, with sign handling done on magnitudes at launch and finish.
module ex_muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             flush,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] N,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [2:0] OP_MUL  = 3'b000;
    localparam logic [2:0] OP_MULH = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_DIV  = 3'b100;
    localparam logic [2:0] OP_REM  = 3'b110;

    function automatic logic [WIDTH-1:0] cneg_w(input logic [WIDTH-1:0] v, input logic en);
        return en ? (~v + 1'b1) : v;
    endfunction

    function automatic logic [2*WIDTH-1:0] cneg_2w(input logic [2*WIDTH-1:0] v, input logic en);
        return en ? (~v + 1'b1) : v;
    endfunction

    logic [1:0]       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [2:0]       op_q, op_d;
    logic             neg_q, neg_d;
    // acc holds the product high half (multiply) or partial remainder (divide);
    // lo holds the multiplier (multiply) or the dividend/quotient (divide).
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] result_q, result_d;

    logic             sa, sn, signed_a, signed_n;
    logic [WIDTH-1:0] abs_a, abs_n;
    logic             div_zero, div_ovf;
    logic [WIDTH-1:0] special_res;

    logic [WIDTH:0]     mul_sum;
    logic [WIDTH-1:0]   mul_hi_n, mul_lo_n;
    logic [2*WIDTH-1:0] prod_s;
    logic [WIDTH:0]     div_shift, div_diff;
    logic               div_ok;
    logic [WIDTH-1:0]   div_rem_n, div_quo_n;
    logic [WIDTH-1:0]   final_res;

    always_comb begin
        signed_a = (op == OP_MUL) || (op == OP_MULH) || (op == OP_MULHSU)
                || (op == OP_DIV) || (op == OP_REM);
        signed_n = (op == OP_MUL) || (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
        sa       = signed_a & A[WIDTH-1];
        sn       = signed_n & N[WIDTH-1];
        abs_a    = cneg_w(A, sa);
        abs_n    = cneg_w(N, sn);
        div_zero = op[2] && (N == '0);
        div_ovf  = ((op == OP_DIV) || (op == OP_REM)) && (A == MIN_NEG) && (N == '1);
        if (div_zero) begin
            special_res = op[1] ? A : '1;
        end else begin
            special_res = op[1] ? '0 : MIN_NEG;
        end
    end

    // One iteration of each algorithm; only the one selected by op_q is committed.
    always_comb begin
        mul_sum   = {1'b0, acc_q} + (lo_q[0] ? {1'b0, b_q} : '0);
        mul_hi_n  = mul_sum[WIDTH:1];
        mul_lo_n  = {mul_sum[0], lo_q[WIDTH-1:1]};
        prod_s    = cneg_2w({mul_hi_n, mul_lo_n}, neg_q);

        div_shift = {acc_q, lo_q[WIDTH-1]};
        div_diff  = div_shift - {1'b0, b_q};
        div_ok    = ~div_diff[WIDTH];
        div_rem_n = div_ok ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
        div_quo_n = {lo_q[WIDTH-2:0], div_ok};

        if (op_q[2]) begin
            final_res = cneg_w(op_q[1] ? div_rem_n : div_quo_n, neg_q);
        end else if (op_q == OP_MUL) begin
            final_res = prod_s[WIDTH-1:0];
        end else begin
            final_res = prod_s[2*WIDTH-1:WIDTH];
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        neg_d    = neg_q;
        acc_d    = acc_q;
        lo_d     = lo_q;
        b_d      = b_q;
        result_d = result_q;
        if (flush) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        op_d  = op;
                        neg_d = (op[2] && op[1]) ? sa : (sa ^ sn);
                        cnt_d = '0;
                        acc_d = '0;
                        lo_d  = op[2] ? abs_a : abs_n;
                        b_d   = op[2] ? abs_n : abs_a;
                        if (div_zero || div_ovf) begin
                            result_d = special_res;
                            state_d  = S_DONE;
                        end else begin
                            state_d  = S_CALC;
                        end
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_CALC: begin
                    cnt_d = cnt_q + CW'(1);
                    acc_d = op_q[2] ? div_rem_n : mul_hi_n;
                    lo_d  = op_q[2] ? div_quo_n : mul_lo_n;
                    if (cnt_q == CNT_LAST) begin
                        result_d = final_res;
                        state_d  = S_DONE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            op_q     <= '0;
            neg_q    <= 1'b0;
            acc_q    <= '0;
            lo_q     <= '0;
            b_q      <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            neg_q    <= neg_d;
            acc_q    <= acc_d;
            lo_q     <= lo_d;
            b_q      <= b_d;
            result_q <= result_d;
        end
    end

    assign busy   = (state_q == S_CALC);
    assign done   = (state_q == S_DONE);
    assign result = result_q;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Scoreboard bench for ex_muldiv_unit: stimulus pushes expected result and done cycle,
// a negedge monitor pops and checks on every done pulse.
module tb_ex_muldiv_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        flush;
    logic [2:0]  op;
    logic [31:0] A;
    logic [31:0] N;
    logic        busy;
    logic        done;
    logic [31:0] result;

    ex_muldiv_unit #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .start(start), .flush(flush), .op(op),
        .A(A), .N(N), .busy(busy), .done(done), .result(result)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] res;
        int          cyc;
        string       name;
    } exp_t;

    exp_t        sb[$];
    int          tests = 0;
    int          fails = 0;
    int          cyc = 0;
    logic [31:0] last_exp = 32'h0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s actual=%h required=%h", nm, act, req);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!reset && done) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_done actual=1 required=0 at cycle %0d", cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check(e.name, result, e.res);
                check({e.name, "_cycle"}, 32'(cyc), 32'(e.cyc));
                check({e.name, "_busy_with_done"}, {31'b0, busy}, 32'h0);
            end
        end
    end

    // Called at a negedge; start is sampled at the following posedge.
    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] n,
                         input logic [31:0] exp_res, input bit special, input string nm);
        exp_t e;
        e.res  = exp_res;
        e.cyc  = cyc + 1 + (special ? 0 : 32);
        e.name = nm;
        sb.push_back(e);
        last_exp = exp_res;
        start = 1'b1;
        op = o;
        A = a;
        N = n;
        @(negedge clk);
        start = 1'b0;
        op = 3'($urandom);
        A = $urandom;
        N = $urandom;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge clk);
        if (sb.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL timeout_waiting_done actual=%0d pending required=0", sb.size());
            sb.delete();
        end
        @(negedge clk);
    endtask

    task automatic run(input logic [2:0] o, input logic [31:0] a, input logic [31:0] n,
                       input logic [31:0] exp_res, input bit special, input string nm);
        issue(o, a, n, exp_res, special, nm);
        wait_idle();
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        flush = 1'b0;
        op = 3'b0;
        A = 32'h0;
        N = 32'h0;
        repeat (3) @(negedge clk);
        check("reset_busy", {31'b0, busy}, 32'h0);
        check("reset_done", {31'b0, done}, 32'h0);
        check("reset_result", result, 32'h0);
        reset = 1'b0;
        @(negedge clk);

        run(3'b000, 32'd7, 32'hFFFF_FFFA, 32'hFFFF_FFD6, 0, "mul_7_m6");
        run(3'b000, 32'h1234_5678, 32'h10, 32'h2345_6780, 0, "mul_shift");
        run(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 0, "mulhu_max");
        run(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 0, "mulh_m1");
        run(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, "mulhsu_m1");
        run(3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 0, "mulh_min_min");
        run(3'b001, 32'h8000_0000, 32'h1, 32'hFFFF_FFFF, 0, "mulh_min_1");
        run(3'b011, 32'h8000_0000, 32'h4, 32'h2, 0, "mulhu_carry");
        run(3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 0, "div_m7_2");
        run(3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 0, "rem_m7_2");
        run(3'b100, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 0, "div_7_m2");
        run(3'b110, 32'd7, 32'hFFFF_FFFE, 32'h1, 0, "rem_7_m2");
        run(3'b100, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'h3, 0, "div_m7_m2");
        run(3'b110, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 0, "rem_m7_m2");
        run(3'b101, 32'd100, 32'd7, 32'd14, 0, "divu_100_7");
        run(3'b111, 32'd100, 32'd7, 32'd2, 0, "remu_100_7");
        run(3'b101, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 0, "divu_max_1");
        run(3'b100, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, "div_by_zero");
        run(3'b111, 32'd5, 32'd0, 32'd5, 1, "remu_by_zero");
        run(3'b101, 32'd9, 32'd0, 32'hFFFF_FFFF, 1, "divu_by_zero");
        run(3'b110, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 1, "rem_by_zero");
        run(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, "div_overflow");
        run(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 1, "rem_overflow");

        // Flush mid-multiply: no done, previous result held.
        start = 1'b1; op = 3'b000; A = 32'd3; N = 32'd3;
        @(negedge clk);
        start = 1'b0;
        repeat (14) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_busy", {31'b0, busy}, 32'h0);
        repeat (40) @(negedge clk);
        check("flush_result_held", result, last_exp);

        // Flush and start together: start is dropped.
        start = 1'b1; flush = 1'b1; op = 3'b000; A = 32'd4; N = 32'd4;
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        check("flush_start_busy", {31'b0, busy}, 32'h0);
        repeat (40) @(negedge clk);
        check("flush_start_result", result, last_exp);

        // Back-to-back: second start issued in the DONE cycle of the first.
        issue(3'b000, 32'd6, 32'd7, 32'd42, 0, "b2b_first");
        begin
            bit seen = 0;
            for (int i = 0; i < 60 && !seen; i++) begin
                if (done) seen = 1;
                else @(negedge clk);
            end
            if (seen) begin
                issue(3'b101, 32'd1000, 32'd10, 32'd100, 0, "b2b_second");
            end else begin
                tests++;
                fails++;
                $display("FAIL b2b_first_done actual=0 required=1");
            end
        end
        wait_idle();

        // Asynchronous reset in the middle of a calculation.
        start = 1'b1; op = 3'b011; A = 32'hFFFF_FFFF; N = 32'd2;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        check("pre_reset_busy", {31'b0, busy}, 32'h1);
        #1 reset = 1'b1;
        #1;
        check("midcalc_reset_busy", {31'b0, busy}, 32'h0);
        check("midcalc_reset_done", {31'b0, done}, 32'h0);
        check("midcalc_reset_result", result, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        repeat (40) @(negedge clk);
        check("post_reset_busy", {31'b0, busy}, 32'h0);
        check("post_reset_result", result, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
